// File: rtl/dvv_mbox_arb.sv
// Multi-channel mailbox: NCH per-channel FIFOs merged onto one registered valid/ready stream.
// Round-robin or fixed-priority grant; a beat pushed at edge N is visible after edge N+1.
module dvv_mbox_arb #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int NCH      = 4,
   parameter int ARB_MODE = 0
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NCH*WIDTH-1:0]                in_data,
   input  logic [NCH-1:0]                      in_valid,
   output logic [NCH-1:0]                      in_ready,
   input  logic [NCH-1:0]                      ch_en,
   input  logic [NCH-1:0]                      ch_flush,
   output logic [WIDTH-1:0]                    out_data,
   output logic [$clog2(NCH)-1:0]              out_ch,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [NCH*($clog2(DEPTH)+1)-1:0]    ch_cnt
);
   localparam int CW = $clog2(NCH);
   localparam int PW = $clog2(DEPTH);
   localparam int NW = PW + 1;
   localparam logic [NW-1:0] FULL = NW'(DEPTH);

   logic [WIDTH-1:0] mem_q [NCH][DEPTH];
   logic [WIDTH-1:0] mem_d [NCH][DEPTH];
   logic [PW-1:0]    wptr_q [NCH];
   logic [PW-1:0]    wptr_d [NCH];
   logic [PW-1:0]    rptr_q [NCH];
   logic [PW-1:0]    rptr_d [NCH];
   logic [NW-1:0]    cnt_q  [NCH];
   logic [NW-1:0]    cnt_d  [NCH];
   logic [CW-1:0]    last_q, last_d;
   logic [CW-1:0]    out_ch_q, out_ch_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [NCH-1:0]   elig, push, pop;
   logic [CW-1:0]    grant;
   logic             gnt_vld, load;

   always_comb begin
      in_ready = '0;
      elig     = '0;
      push     = '0;
      ch_cnt   = '0;
      for (int i = 0; i < NCH; i++) begin
         in_ready[i]          = (cnt_q[i] != FULL);
         elig[i]              = (cnt_q[i] != '0) && ch_en[i] && !ch_flush[i];
         push[i]              = in_valid[i] && (cnt_q[i] != FULL);
         ch_cnt[i*NW +: NW]   = cnt_q[i];
      end
   end

   // Descending scan so the candidate closest to the search start is assigned last and wins.
   always_comb begin
      grant   = '0;
      gnt_vld = 1'b0;
      if (ARB_MODE == 1) begin
         for (int k = NCH - 1; k >= 0; k--) begin
            if (elig[k]) begin
               grant   = CW'(k);
               gnt_vld = 1'b1;
            end
         end
      end else begin
         for (int k = NCH; k >= 1; k--) begin
            if (elig[(int'(last_q) + k) % NCH]) begin
               grant   = CW'((int'(last_q) + k) % NCH);
               gnt_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      load = gnt_vld && (!out_valid_q || out_ready);
      pop  = '0;
      for (int i = 0; i < NCH; i++) begin
         pop[i] = load && (grant == CW'(i));
      end
   end

   always_comb begin
      mem_d       = mem_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      last_d      = last_q;
      for (int i = 0; i < NCH; i++) begin
         if (ch_flush[i]) begin
            wptr_d[i] = '0;
            rptr_d[i] = '0;
            cnt_d[i]  = '0;
         end else begin
            if (push[i]) begin
               mem_d[i][wptr_q[i]] = in_data[i*WIDTH +: WIDTH];
               wptr_d[i]           = wptr_q[i] + PW'(1);
            end
            if (pop[i]) begin
               rptr_d[i] = rptr_q[i] + PW'(1);
            end
            cnt_d[i] = cnt_q[i] + NW'(push[i]) - NW'(pop[i]);
         end
      end
      if (load) begin
         out_data_d  = mem_q[grant][rptr_q[grant]];
         out_ch_d    = grant;
         out_valid_d = 1'b1;
         last_d      = grant;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Storage needs no reset: pointers and counts alone define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            wptr_q[i] <= '0;
            rptr_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         last_q      <= CW'(NCH - 1);
         out_ch_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         out_ch_q    <= out_ch_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;
endmodule

// File: tb/tb_dvv_mbox_arb.sv
// Bench for dvv_mbox_arb: round-robin and fixed-priority instances share stimulus and are
// checked every cycle against a queue-based model, plus literal directed expectations.
module tb_dvv_mbox_arb;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int N  = 4;
   localparam int CW = 2;
   localparam int NW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [N*W-1:0]   in_data;
   logic [N-1:0]     in_valid, ch_en, ch_flush;
   logic             out_ready;
   logic [N-1:0]     in_ready_w  [2];
   logic [W-1:0]     out_data_w  [2];
   logic [CW-1:0]    out_ch_w    [2];
   logic             out_valid_w [2];
   logic [N*NW-1:0]  ch_cnt_w    [2];

   dvv_mbox_arb #(.WIDTH(W), .DEPTH(D), .NCH(N), .ARB_MODE(0)) dut_rr (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_w[0]),
      .ch_en(ch_en), .ch_flush(ch_flush), .out_data(out_data_w[0]), .out_ch(out_ch_w[0]),
      .out_valid(out_valid_w[0]), .out_ready(out_ready), .ch_cnt(ch_cnt_w[0]));

   dvv_mbox_arb #(.WIDTH(W), .DEPTH(D), .NCH(N), .ARB_MODE(1)) dut_fp (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_w[1]),
      .ch_en(ch_en), .ch_flush(ch_flush), .out_data(out_data_w[1]), .out_ch(out_ch_w[1]),
      .out_valid(out_valid_w[1]), .out_ready(out_ready), .ch_cnt(ch_cnt_w[1]));

   // Model state per instance: channel contents as queues plus the output register.
   logic [W-1:0] mq [2][N][$];
   bit           mov   [2];
   int           mod   [2];
   int           moch  [2];
   int           mlast [2];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            for (int c = 0; c < N; c++) mq[m][c].delete();
            mov[m] = 0; mod[m] = 0; moch[m] = 0; mlast[m] = N - 1;
         end else begin
            int g;
            bit acc [N];
            g = -1;
            for (int k = 0; k < N; k++) begin
               int c;
               c = (m == 0) ? (mlast[m] + 1 + k) % N : k;
               if (g < 0 && mq[m][c].size() > 0 && ch_en[c] && !ch_flush[c]) g = c;
            end
            for (int c = 0; c < N; c++) acc[c] = in_valid[c] && (mq[m][c].size() < D);
            if (g >= 0 && (!mov[m] || out_ready)) begin
               mod[m]   = int'(mq[m][g].pop_front());
               moch[m]  = g;
               mov[m]   = 1;
               mlast[m] = g;
            end else if (out_ready) begin
               mov[m] = 0;
            end
            for (int c = 0; c < N; c++) begin
               if (ch_flush[c]) mq[m][c].delete();
               else if (acc[c]) mq[m][c].push_back(in_data[c*W +: W]);
            end
         end
      end
   endtask

   task automatic check_all();
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("out_valid[%0d]", m), int'(out_valid_w[m]), int'(mov[m]));
         chk($sformatf("out_data[%0d]", m),  int'(out_data_w[m]),  mod[m]);
         chk($sformatf("out_ch[%0d]", m),    int'(out_ch_w[m]),    moch[m]);
         for (int c = 0; c < N; c++) begin
            chk($sformatf("ch_cnt[%0d][%0d]", m, c), int'(ch_cnt_w[m][c*NW +: NW]),
                mq[m][c].size());
            chk($sformatf("in_ready[%0d][%0d]", m, c), int'(in_ready_w[m][c]),
                int'(mq[m][c].size() != D));
         end
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = '0; ch_flush = '0;
      cycle();
      rst = 1'b0;
   endtask

   int exp_rr [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int exp_fp [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
   int seq_rr [$];
   int seq_fp [$];

   initial begin
      in_data = '0; in_valid = '0; ch_en = '1; ch_flush = '0; out_ready = 1'b1; rst = 1'b1;
      do_reset();
      chk("rst_out_valid", int'(out_valid_w[0]), 0);
      chk("rst_out_data",  int'(out_data_w[0]), 0);
      chk("rst_out_ch",    int'(out_ch_w[0]), 0);
      chk("rst_ch_cnt",    int'(ch_cnt_w[0]), 0);
      chk("rst_in_ready",  int'(in_ready_w[0]), 4'hF);

      // Single beat latency on ch2
      in_valid = 4'b0100; in_data = 32'h00A5_0000;
      cycle();
      in_valid = '0;
      chk("lat_not_yet", int'(out_valid_w[0]), 0);
      cycle();
      chk("lat_valid", int'(out_valid_w[0]), 1);
      chk("lat_data",  int'(out_data_w[0]), 8'hA5);
      chk("lat_ch",    int'(out_ch_w[0]), 2);
      cycle();
      chk("lat_drop", int'(out_valid_w[0]), 0);
      chk("lat_cnt",  int'(ch_cnt_w[0]), 0);

      // Preload 2 beats per channel, then drain through both arbiters
      do_reset();
      ch_en = '0; out_ready = 1'b1;
      for (int j = 0; j < 2; j++) begin
         in_valid = 4'hF;
         in_data  = {8'h30 | 8'(j), 8'h20 | 8'(j), 8'h10 | 8'(j), 8'h00 | 8'(j)};
         cycle();
      end
      in_valid = '0; ch_en = 4'hF;
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (out_valid_w[0]) seq_rr.push_back(int'(out_ch_w[0]));
         if (out_valid_w[1]) seq_fp.push_back(int'(out_ch_w[1]));
      end
      chk("rr_len", seq_rr.size(), 8);
      chk("fp_len", seq_fp.size(), 8);
      for (int k = 0; k < 8 && k < seq_rr.size(); k++) chk($sformatf("rr_seq%0d", k), seq_rr[k], exp_rr[k]);
      for (int k = 0; k < 8 && k < seq_fp.size(); k++) chk($sformatf("fp_seq%0d", k), seq_fp[k], exp_fp[k]);

      // Fill ch1 while stalled; refused write during a pop
      do_reset();
      ch_en = 4'hF; out_ready = 1'b0;
      for (int b = 1; b <= 5; b++) begin
         in_valid = 4'b0010; in_data = {16'h0, 8'(b), 8'h0};
         cycle();
      end
      in_valid = '0;
      cycle();
      chk("full_cnt",   int'(ch_cnt_w[0][5:3]), 4);
      chk("full_rdy",   int'(in_ready_w[0][1]), 0);
      chk("full_hold",  int'(out_data_w[0]), 1);
      in_valid = 4'b0010; in_data = {16'h0, 8'd6, 8'h0}; out_ready = 1'b1;
      cycle();
      in_valid = '0; out_ready = 1'b0;
      chk("refuse_cnt",  int'(ch_cnt_w[0][5:3]), 3);
      chk("refuse_data", int'(out_data_w[0]), 2);

      // Disabled channel retains data and resumes in order
      do_reset();
      ch_en = '0; out_ready = 1'b1;
      in_valid = 4'b0011; in_data = {16'h0, 8'h20, 8'h10};
      cycle();
      in_data = {16'h0, 8'h21, 8'h11};
      cycle();
      in_valid = '0; ch_en = 4'b0010;
      cycle(); chk("dis_a", int'(out_data_w[0]), 8'h20);
      cycle(); chk("dis_b", int'(out_data_w[0]), 8'h21);
      cycle(); chk("dis_idle", int'(out_valid_w[0]), 0);
      ch_en = 4'hF;
      cycle(); chk("dis_c", int'(out_data_w[0]), 8'h10);
      cycle(); chk("dis_d", int'(out_data_w[0]), 8'h11);

      // Flush ch3 with a same-cycle write while a beat sits in the output register
      do_reset();
      ch_en = '0; out_ready = 1'b0;
      for (int b = 1; b <= 3; b++) begin
         in_valid = 4'b1000; in_data = {8'h30 | 8'(b), 24'h0};
         cycle();
      end
      in_valid = '0; ch_en = 4'hF;
      cycle();
      ch_flush = 4'b1000; in_valid = 4'b1000; in_data = 32'h3400_0000;
      cycle();
      ch_flush = '0; in_valid = '0;
      chk("flush_cnt",   int'(ch_cnt_w[0][11:9]), 0);
      chk("flush_valid", int'(out_valid_w[0]), 1);
      chk("flush_data",  int'(out_data_w[0]), 8'h31);
      out_ready = 1'b1;
      cycle();
      chk("flush_idle",  int'(out_valid_w[0]), 0);

      // Randomized traffic including occasional flush and reset
      for (int n = 0; n < 3000; n++) begin
         in_valid  = 4'($urandom);
         in_data   = $urandom;
         ch_en     = 4'($urandom) | 4'($urandom);
         ch_flush  = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 299) == 0);
         cycle();
      end

      // Mid-stream reset
      rst = 1'b0; ch_flush = '0; ch_en = 4'hF; out_ready = 1'b0; in_valid = 4'hF; in_data = 32'h5566_7788;
      cycle(); cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0; in_valid = '0;
      chk("mid_rst_valid", int'(out_valid_w[0]), 0);
      chk("mid_rst_data",  int'(out_data_w[0]), 0);
      chk("mid_rst_cnt",   int'(ch_cnt_w[0]), 0);
      chk("mid_rst_fpcnt", int'(ch_cnt_w[1]), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
